// File: rtl/retry_buffer_pkg.sv
// Shared types and helpers for the data-link retry buffer.
//   tx_state_t    : transmit FSM state encoding (IDLE, SEND, GAP)
//   REPLAY_NUM_W  : width of the replay-attempt counter
//   seq_covered() : true when a stored sequence number is at or behind an
//                   AckNak sequence number, using modulo-2^w arithmetic
package retry_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  localparam int REPLAY_NUM_W = 2;

  // Entry seq is covered by ack when (ack - seq) mod 2^w lies in the lower
  // half of the sequence space, i.e. seq is not "ahead" of ack.
  function automatic logic seq_covered(input logic [31:0] ack,
                                       input logic [31:0] seq,
                                       input int unsigned w);
    logic [31:0] mask;
    logic [31:0] diff;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    diff = (ack - seq) & mask;
    return diff < (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/retry_buffer_mem.sv
// TLP slot storage: DEPTH slots of TLP_WORDS words each.
//   clk        : clock
//   wr_en_i    : write a whole TLP into slot wr_slot_i
//   wr_slot_i  : slot index for the write
//   wr_data_i  : TLP, word k at [k*DATA_W +: DATA_W]
//   rd_en_i    : load the read register from (rd_slot_i, rd_word_i)
//   rd_slot_i  : slot index for the read
//   rd_word_i  : word index within the slot
//   rd_data_o  : registered read word; holds while rd_en_i is low
module retry_buffer_mem #(
  parameter int DATA_W    = 16,
  parameter int TLP_WORDS = 10,
  parameter int DEPTH     = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int WW = (TLP_WORDS > 1) ? $clog2(TLP_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        wr_en_i,
  input  logic [AW-1:0]               wr_slot_i,
  input  logic [TLP_WORDS*DATA_W-1:0] wr_data_i,
  input  logic                        rd_en_i,
  input  logic [AW-1:0]               rd_slot_i,
  input  logic [WW-1:0]               rd_word_i,
  output logic [DATA_W-1:0]           rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH][TLP_WORDS];
  logic [DATA_W-1:0] rd_data_q;

  // Storage is never reset: slot contents only matter once written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int k = 0; k < TLP_WORDS; k++) begin
        mem_q[wr_slot_i][k] <= wr_data_i[k*DATA_W +: DATA_W];
      end
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_slot_i][rd_word_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/retry_buffer.sv
// Transmit-side data-link retry buffer. Whole TLPs are written with their
// sequence number, streamed out word by word, purged on ACK and replayed
// in order on NAK or replay-timer expiry.
//   clk, rst           : clock, synchronous active-high reset
//   wr_en/wr_seq/wr_data : TLP write (ignored while full)
//   full/empty/count   : occupancy
//   ack_valid/ack_nak/ack_seq : ACK/NAK DLLP strobe
//   tim_out            : replay timer expiry pulse
//   tx_data/tx_valid/tx_ready/tx_sop/tx_eop : word stream to PHY mux
//   replaying          : replay in progress
//   retrain            : one-cycle pulse when the replay count rolls over
// Optional feature macro: RETRY_REPLAY_LIMIT_EN enables the replay-attempt
// counter; without it retrain is tied low.
module retry_buffer
  import retry_buffer_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TLP_WORDS = 10,
  parameter int DEPTH     = 8,
  parameter int SEQ_W     = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [SEQ_W-1:0]            wr_seq,
  input  logic [TLP_WORDS*DATA_W-1:0] wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  input  logic                        ack_valid,
  input  logic                        ack_nak,
  input  logic [SEQ_W-1:0]            ack_seq,
  input  logic                        tim_out,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        tx_sop,
  output logic                        tx_eop,
  output logic                        replaying,
  output logic                        retrain
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = (TLP_WORDS > 1) ? $clog2(TLP_WORDS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(TLP_WORDS - 1);

  // Pointers carry one extra wrap bit so full and all-sent are distinct
  // from empty and none-sent.
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, rd_q, rd_d;
  logic [PW-1:0]    rep_tail_q, rep_tail_d;
  tx_state_t        state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             rep_pend_q, rep_pend_d;
  logic             replaying_q, replaying_d;
  logic [SEQ_W-1:0] seq_q [DEPTH];

  logic [PW-1:0]    occ, sent, purge_n, purge_amt, rd_eff;
  logic             wr_acc, run, rep_pend, boundary, start, drop, fire;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_rd_slot;
  logic [WW-1:0]    mem_rd_word;

  assign occ    = tail_q - head_q;
  assign sent   = rd_q - head_q;  // slot rd is never complete, even in SEND
  assign full   = (occ == PW'(DEPTH));
  assign empty  = (occ == '0);
  assign count  = occ;
  assign wr_acc = wr_en && !full;

  // Longest run of covered, fully transmitted entries starting at head.
  always_comb begin
    purge_n = '0;
    run     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && (PW'(i) < sent) &&
          seq_covered(32'(ack_seq), 32'(seq_q[head_q[AW-1:0] + AW'(i)]), SEQ_W)) begin
        purge_n = PW'(i + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

  assign purge_amt = ack_valid ? purge_n : '0;
  assign head_d    = head_q + purge_amt;
  assign tail_d    = wr_acc ? tail_q + PW'(1) : tail_q;

  // A request raised this cycle is seen immediately at a boundary; the
  // purge of a same-cycle ACK/NAK is already folded into head_d.
  assign rep_pend = rep_pend_q || (ack_valid && ack_nak) || tim_out;
  assign boundary = (state_q != SEND);
  assign start    = boundary && rep_pend && (head_d != tail_q);
  assign drop     = boundary && rep_pend && (head_d == tail_q);
  assign rd_eff   = start ? head_d : rd_q;
  assign fire     = (state_q == SEND) && tx_ready;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rd_d        = rd_q;
    mem_rd_en   = 1'b0;
    mem_rd_slot = rd_q[AW-1:0];
    mem_rd_word = '0;
    case (state_q)
      IDLE, GAP: begin
        rd_d = rd_eff;
        if (rd_eff != tail_q) begin
          // Prefetch word 0 so it is on tx_data in the first SEND cycle.
          state_d     = SEND;
          wcnt_d      = '0;
          mem_rd_en   = 1'b1;
          mem_rd_slot = rd_eff[AW-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (fire) begin
          if (wcnt_q == LAST_W) begin
            rd_d    = rd_q + PW'(1);
            state_d = GAP;
          end else begin
            wcnt_d      = wcnt_q + WW'(1);
            mem_rd_en   = 1'b1;
            mem_rd_word = wcnt_q + WW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rep_pend_d  = (start || drop) ? 1'b0 : rep_pend;
    rep_tail_d  = start ? tail_q : rep_tail_q;
    replaying_d = replaying_q;
    if (start) begin
      replaying_d = 1'b1;
    end else if (drop || (replaying_q && rd_d == rep_tail_q)) begin
      replaying_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      rd_q        <= '0;
      rep_tail_q  <= '0;
      state_q     <= IDLE;
      wcnt_q      <= '0;
      rep_pend_q  <= 1'b0;
      replaying_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      rd_q        <= rd_d;
      rep_tail_q  <= rep_tail_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rep_pend_q  <= rep_pend_d;
      replaying_q <= replaying_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      seq_q[tail_q[AW-1:0]] <= wr_seq;
    end
  end

  retry_buffer_mem #(
    .DATA_W    (DATA_W),
    .TLP_WORDS (TLP_WORDS),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (wr_acc),
    .wr_slot_i (tail_q[AW-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (mem_rd_en),
    .rd_slot_i (mem_rd_slot),
    .rd_word_i (mem_rd_word),
    .rd_data_o (tx_data)
  );

  assign tx_valid  = (state_q == SEND);
  assign tx_sop    = tx_valid && (wcnt_q == '0);
  assign tx_eop    = tx_valid && (wcnt_q == LAST_W);
  assign replaying = replaying_q;

`ifdef RETRY_REPLAY_LIMIT_EN
  logic [REPLAY_NUM_W-1:0] replay_num_q, replay_num_d, replay_base;
  logic                    retrain_q, retrain_d;

  // A purging ACK/NAK clears the count before a same-cycle replay start
  // increments it.
  always_comb begin
    replay_base  = (purge_amt != '0) ? '0 : replay_num_q;
    replay_num_d = replay_base;
    retrain_d    = 1'b0;
    if (start) begin
      if (replay_base == '1) begin
        replay_num_d = '0;
        retrain_d    = 1'b1;
      end else begin
        replay_num_d = replay_base + REPLAY_NUM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      replay_num_q <= '0;
      retrain_q    <= 1'b0;
    end else begin
      replay_num_q <= replay_num_d;
      retrain_q    <= retrain_d;
    end
  end

  assign retrain = retrain_q;
`else
  assign retrain = 1'b0;
`endif

endmodule
